// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 keyboard controller.
// Covers register indices, frame FSM states, STATUS/CTRL bit positions and the frame parity check.
package kbd_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_PERR    = 1;
  localparam int STAT_FERR    = 2;
  localparam int STAT_OVF     = 3;

  localparam int CTRL_INT_EN     = 0;
  localparam int CTRL_ERR_INT_EN = 1;
  localparam int CTRL_FLUSH      = 8;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data_b, input logic par_b);
    return ^{data_b, par_b};
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous 8-bit scan-code FIFO with flush and full/empty/count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module kbd_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [7:0]               push_data_i,
  input  logic                     pop_i,
  output logic [7:0]               head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push_s, do_pop_s;

  // Pop only real data; a full FIFO still takes a push when a pop frees a slot.
  always_comb begin
    empty_o   = (count_q == CW'(0));
    full_o    = (count_q == CW'(DEPTH));
    do_pop_s  = pop_i & ~empty_o;
    do_push_s = push_i & (~full_o | do_pop_s);
    drop_o    = push_i & ~do_push_s & ~flush_i;
    head_o    = mem_q[rd_ptr_q];
    count_o   = count_q;
  end

  // Pointer and occupancy bookkeeping; flush wins over any push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard receiver: pin conditioning, 11-bit frame deframer, scan-code FIFO and CPU register window.
// Define PS2_TIMEOUT_EN to abort frames that stall mid-way for TIMEOUT_CYC clk cycles.
module ps2_kbd_ctrl
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        int_o
);

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic          filt_q;
  logic [FW-1:0] filt_cnt_q;
  logic          strike_q, strike_dat_q;

  frame_state_e  state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          push_s, ferr_set_s, perr_set_s;

  logic          sel_rd_s, sel_wr_s, pop_s, flush_s;
  logic [2:0]    clr_s;
  logic          perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic          int_q, int_d;
  logic [31:0]   rdata_q, rd_val_s;
  logic [7:0]    cnt8_s;

  logic [7:0]    fifo_head_s;
  logic          fifo_full_s, fifo_empty_s, fifo_drop_s;
  logic [CW-1:0] fifo_count_s;
  logic          unused_s;

  // Two-flop synchronizers; idle PS/2 lines are high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_i;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_data_i;
      dat_sync_q <= dat_meta_q;
    end
  end

  // Clock deglitcher; a 1->0 change of the filtered clock becomes a one-cycle strike.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q       <= 1'b1;
      filt_cnt_q   <= '0;
      strike_q     <= 1'b0;
      strike_dat_q <= 1'b1;
    end else begin
      strike_q     <= 1'b0;
      strike_dat_q <= dat_sync_q;
      if (clk_sync_q == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q     <= clk_sync_q;
        filt_cnt_q <= '0;
        strike_q   <= filt_q;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt_q;
  logic          tmo_hit_s;

  assign tmo_hit_s = (state_q != ST_IDLE) && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

  // Stall watchdog: restarts on every strike and is held clear while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (strike_q || state_q == ST_IDLE || tmo_hit_s) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  logic tmo_hit_s;
  assign tmo_hit_s = 1'b0;
`endif

  // Frame deframer next-state logic.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    push_s     = 1'b0;
    ferr_set_s = 1'b0;
    perr_set_s = 1'b0;
    if (strike_q) begin
      case (state_q)
        ST_IDLE: begin
          if (!strike_dat_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            ferr_set_s = 1'b1;
          end
        end
        ST_DATA: begin
          shift_d = {strike_dat_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        ST_PARITY: begin
          par_d   = strike_dat_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d    = ST_IDLE;
          perr_set_s = ~odd_parity_ok(shift_q, par_q);
          ferr_set_s = ~strike_dat_q;
          push_s     = odd_parity_ok(shift_q, par_q) & strike_dat_q;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (tmo_hit_s) begin
      state_d    = ST_IDLE;
      ferr_set_s = 1'b1;
    end else begin
      state_d = state_q;
    end
  end

  // Frame deframer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
    end
  end

  kbd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_s),
    .push_i      (push_s),
    .push_data_i (shift_q),
    .pop_i       (pop_s),
    .head_o      (fifo_head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .drop_o      (fifo_drop_s),
    .count_o     (fifo_count_s)
  );

  // Register decode, sticky flags with write-1-to-clear (a new event beats the clear), and read mux.
  always_comb begin
    sel_rd_s = cs & rd;
    sel_wr_s = cs & wr;
    pop_s    = sel_rd_s & (addr == REG_DATA);
    flush_s  = sel_wr_s & (addr == REG_CTRL) & wdata[CTRL_FLUSH];
    clr_s    = (sel_wr_s && addr == REG_STATUS) ? wdata[STAT_OVF:STAT_PERR] : 3'b000;
    perr_d   = (perr_q & ~clr_s[0]) | perr_set_s;
    ferr_d   = (ferr_q & ~clr_s[1]) | ferr_set_s;
    ovf_d    = (ovf_q  & ~clr_s[2]) | fifo_drop_s;
    if (sel_wr_s && addr == REG_CTRL) begin
      ctrl_d = wdata[CTRL_ERR_INT_EN:CTRL_INT_EN];
    end else begin
      ctrl_d = ctrl_q;
    end
    int_d  = (ctrl_q[CTRL_INT_EN] & ~fifo_empty_s) |
             (ctrl_q[CTRL_ERR_INT_EN] & (ovf_q | ferr_q | perr_q));
    cnt8_s = 8'(fifo_count_s);
    case (addr)
      REG_DATA: begin
        if (fifo_empty_s) begin
          rd_val_s = 32'h0000_0000;
        end else begin
          rd_val_s = {23'd0, 1'b1, fifo_head_s};
        end
      end
      REG_STATUS: rd_val_s = {16'd0, cnt8_s, 4'd0, ovf_q, ferr_q, perr_q, fifo_empty_s};
      REG_CTRL:   rd_val_s = {30'd0, ctrl_q};
      REG_RSVD:   rd_val_s = 32'h0000_0000;
      default:    rd_val_s = 32'h0000_0000;
    endcase
  end

  // Register state and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ctrl_q  <= 2'b00;
      int_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      ovf_q  <= ovf_d;
      ctrl_q <= ctrl_d;
      int_q  <= int_d;
      if (sel_rd_s) rdata_q <= rd_val_s;
    end
  end

  assign rdata    = rdata_q;
  assign int_o    = int_q;
  assign unused_s = ^{wdata[31:9], wdata[7:4], wdata[0], fifo_full_s, TIMEOUT_CYC[0]};

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: randomized PS/2 frames against a queue-based register model.
`timescale 1ns/1ps
module tb_ps2_kbd_ctrl;

  localparam int DEPTH = 16;
  localparam int FLEN  = 8;
  localparam int TMO   = 1000;
  localparam int H     = 40;

  logic clk = 1'b0, rst_n = 1'b0;
  logic ps2_clk = 1'b1, ps2_data = 1'b1;
  logic cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        int_o;

  int n_vec = 0, n_err = 0;

  byte unsigned mq[$];
  bit m_ovf, m_fe, m_pe, m_int_en, m_err_en;

  always #5 clk = ~clk;

  ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
    .cs(cs), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata), .int_o(int_o)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic model_int();
    return (m_int_en && mq.size() != 0) || (m_err_en && (m_ovf || m_fe || m_pe));
  endfunction

  task automatic model_reset();
    mq.delete();
    {m_ovf, m_fe, m_pe, m_int_en, m_err_en} = 5'b0;
  endtask

  task automatic model_read(input logic [1:0] a, output logic [31:0] v);
    v = 32'd0;
    case (a)
      2'd0: if (mq.size() != 0) v = {23'd0, 1'b1, mq.pop_front()};
      2'd1: v = {16'd0, 8'(mq.size()), 4'd0, m_ovf, m_fe, m_pe, mq.size() == 0};
      2'd2: v = {30'd0, m_err_en, m_int_en};
      default: v = 32'd0;
    endcase
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] got, output logic [31:0] exp);
    @(negedge clk); cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk); cs = 1'b0; rd = 1'b0;
    got = rdata;
    model_read(a, exp);
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk); cs = 1'b0; wr = 1'b0;
    if (a == 2'd1) begin
      if (d[1]) m_pe = 1'b0;
      if (d[2]) m_fe = 1'b0;
      if (d[3]) m_ovf = 1'b0;
    end else if (a == 2'd2) begin
      m_int_en = d[0];
      m_err_en = d[1];
      if (d[8]) mq.delete();
    end
  endtask

  task automatic ps2_bit(input bit b);
    ps2_data = b;
    wait_clk(H / 2);
    ps2_clk = 1'b0;
    wait_clk(H);
    ps2_clk = 1'b1;
    wait_clk(H / 2);
  endtask

  task automatic send_frame(input byte unsigned d, input bit par_bad, input bit stop_bad);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ par_bad);
    ps2_bit(~stop_bad);
    ps2_data = 1'b1;
    wait_clk(H);
    if (par_bad) m_pe = 1'b1;
    if (stop_bad) m_fe = 1'b1;
    if (!par_bad && !stop_bad) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    model_reset();
    wait_clk(3);
    n_vec++; if (rdata !== 32'd0 || int_o !== 1'b0) begin n_err++; $display("FAIL reset_outputs: got rdata=%h int=%b required 0/0", rdata, int_o); end
    rst_n = 1'b1;
    wait_clk(3);
    for (int a = 0; a < 4; a++) begin
      reg_read(2'(a), got, exp);
      n_vec++; if (got !== exp) begin n_err++; $display("FAIL reset_reg%0d: got %h required %h", a, got, exp); end
    end
  endtask

  task automatic test_good_frame();
    logic [31:0] got, exp;
    reg_write(2'd2, 32'h1);
    send_frame(8'h1C, 1'b0, 1'b0);
    n_vec++; if (int_o !== 1'b1) begin n_err++; $display("FAIL good_int: got %b required 1", int_o); end
    reg_read(2'd1, got, exp);
    n_vec++; if (got !== 32'h0000_0100) begin n_err++; $display("FAIL good_status: got %h required %h", got, 32'h100); end
    reg_read(2'd0, got, exp);
    n_vec++; if (got !== 32'h0000_011C) begin n_err++; $display("FAIL good_data: got %h required %h", got, 32'h11C); end
    reg_read(2'd1, got, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL good_empty: got %h required %h", got, exp); end
    wait_clk(3);
    n_vec++; if (int_o !== model_int()) begin n_err++; $display("FAIL good_int_clear: got %b required %b", int_o, model_int()); end
  endtask

  task automatic test_errors();
    logic [31:0] got, exp;
    send_frame(8'h1C, 1'b1, 1'b0);
    reg_read(2'd1, got, exp);
    n_vec++; if (got !== 32'h3) begin n_err++; $display("FAIL perr_status: got %h required %h", got, 32'h3); end
    n_vec++; if (int_o !== 1'b0) begin n_err++; $display("FAIL perr_int_masked: got %b required 0", int_o); end
    reg_write(2'd2, 32'h2);
    wait_clk(3);
    n_vec++; if (int_o !== 1'b1) begin n_err++; $display("FAIL perr_int: got %b required 1", int_o); end
    reg_write(2'd1, 32'h2);
    wait_clk(3);
    n_vec++; if (int_o !== 1'b0) begin n_err++; $display("FAIL perr_clr_int: got %b required 0", int_o); end
    send_frame(8'h33, 1'b0, 1'b1);
    reg_read(2'd1, got, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL stop_err: got %h required %h", got, exp); end
    reg_write(2'd1, 32'h4);
    ps2_bit(1'b1);
    wait_clk(H);
    m_fe = 1'b1;
    reg_read(2'd1, got, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL stray_strike: got %h required %h", got, exp); end
    reg_write(2'd1, 32'hE);
    reg_read(2'd1, got, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL err_clear_all: got %h required %h", got, exp); end
  endtask

  task automatic test_overflow();
    logic [31:0] got, exp;
    reg_write(2'd2, 32'h1);
    for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b0, 1'b0);
    reg_read(2'd1, got, exp);
    n_vec++; if (got !== 32'h0000_1008) begin n_err++; $display("FAIL ovf_status: got %h required %h", got, 32'h1008); end
    for (int i = 0; i < 17; i++) begin
      reg_read(2'd0, got, exp);
      n_vec++; if (got !== exp) begin n_err++; $display("FAIL ovf_read%0d: got %h required %h", i, got, exp); end
    end
    reg_write(2'd1, 32'h8);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b0, 1'b0);
    @(negedge clk); cs = 1'b1; rd = 1'b1; addr = 2'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) begin cs = 1'b0; rd = 1'b0; end
      model_read(2'd0, exp);
      n_vec++; if (rdata !== exp) begin n_err++; $display("FAIL b2b_read%0d: got %h required %h", i, rdata, exp); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] got, exp;
    send_frame(8'hA1, 1'b0, 1'b0);
    send_frame(8'hB2, 1'b0, 1'b0);
    reg_write(2'd2, 32'h101);
    reg_read(2'd1, got, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL flush_status: got %h required %h", got, exp); end
    reg_read(2'd2, got, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL flush_ctrl: got %h required %h", got, exp); end
  endtask

  task automatic test_glitch();
    logic [31:0] got, exp;
    for (int i = 0; i < 20; i++) begin
      wait_clk(199);
      ps2_clk = 1'b0;
      wait_clk(1);
      ps2_clk = 1'b1;
    end
    wait_clk(H);
    reg_read(2'd1, got, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL glitch_status: got %h required %h", got, exp); end
    send_frame(8'h3C, 1'b0, 1'b0);
    reg_read(2'd0, got, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL glitch_frame: got %h required %h", got, exp); end
  endtask

  task automatic test_random();
    logic [31:0] got, exp;
    int r;
    reg_write(2'd2, 32'h3);
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 9);
      send_frame(8'($urandom), r == 0, r == 1);
      n_vec++; if (int_o !== model_int()) begin n_err++; $display("FAIL rnd_int%0d: got %b required %b", n, int_o, model_int()); end
      if ($urandom_range(0, 1) == 1) begin
        reg_read(2'd0, got, exp);
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL rnd_data%0d: got %h required %h", n, got, exp); end
      end
      if ($urandom_range(0, 3) == 0) begin
        reg_read(2'd1, got, exp);
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL rnd_status%0d: got %h required %h", n, got, exp); end
        reg_write(2'd1, 32'hE);
      end
    end
    while (mq.size() != 0) begin
      reg_read(2'd0, got, exp);
      n_vec++; if (got !== exp) begin n_err++; $display("FAIL rnd_drain: got %h required %h", got, exp); end
    end
    reg_read(2'd1, got, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL rnd_final_status: got %h required %h", got, exp); end
    reg_write(2'd1, 32'hE);
  endtask

  task automatic test_reset_midframe();
    logic [31:0] got, exp;
    reg_write(2'd2, 32'h1);
    send_frame(8'h77, 1'b0, 1'b0);
    reg_read(2'd1, got, exp);
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(i[0]);
    ps2_data = 1'b1;
    rst_n = 1'b0;
    model_reset();
    wait_clk(3);
    n_vec++; if (rdata !== 32'd0 || int_o !== 1'b0) begin n_err++; $display("FAIL midreset_outputs: got rdata=%h int=%b required 0/0", rdata, int_o); end
    rst_n = 1'b1;
    wait_clk(3);
    reg_read(2'd1, got, exp);
    n_vec++; if (got !== 32'h1) begin n_err++; $display("FAIL midreset_status: got %h required %h", got, 32'h1); end
    send_frame(8'h5A, 1'b0, 1'b0);
    reg_read(2'd0, got, exp);
    n_vec++; if (got !== 32'h15A) begin n_err++; $display("FAIL midreset_frame: got %h required %h", got, 32'h15A); end
  endtask

`ifdef PS2_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] got, exp;
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
    wait_clk(TMO + 200);
    m_fe = 1'b1;
    reg_read(2'd1, got, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL timeout_status: got %h required %h", got, exp); end
    reg_write(2'd1, 32'h4);
    send_frame(8'hF0, 1'b0, 1'b0);
    reg_read(2'd0, got, exp);
    n_vec++; if (got !== 32'h1F0) begin n_err++; $display("FAIL timeout_frame: got %h required %h", got, 32'h1F0); end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_errors();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_glitch();
    test_random();
`ifdef PS2_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
